// File: rtl/dip_switch_debouncer.sv
// Two-flop synchroniser plus independent per-bit debounce for the board DIP switches.
// Produces registered clean levels and one-cycle rise/fall/changed strobes.
module dip_switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 500000,
  parameter int INVERT        = 0,
  localparam int CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] INV_MASK = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0] clean_nxt_s;

  // Synchroniser chain; polarity is normalised before the second stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= {WIDTH{1'b0}};
      s2_r <= {WIDTH{1'b0}};
    end else begin
      s1_r <= sw_raw ^ INV_MASK;
      s2_r <= s1_r;
    end
  end

  // Next-state per bit: any agreement with the accepted level restarts the qualification run.
  always_comb begin
    clean_nxt_s = sw_clean;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = {CNT_W{1'b0}};
      if (s2_r[i] == sw_clean[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_MAX) begin
        cnt_nxt_s[i]   = {CNT_W{1'b0}};
        clean_nxt_s[i] = s2_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Counters, clean level and strobes all register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      sw_clean   <= {WIDTH{1'b0}};
      sw_rise    <= {WIDTH{1'b0}};
      sw_fall    <= {WIDTH{1'b0}};
      sw_changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      sw_clean   <= clean_nxt_s;
      sw_rise    <= clean_nxt_s & ~sw_clean;
      sw_fall    <= ~clean_nxt_s & sw_clean;
      sw_changed <= |(clean_nxt_s ^ sw_clean);
    end
  end

endmodule

// File: tb/tb_dip_switch_debouncer.sv
// Randomised and directed bench for dip_switch_debouncer (WIDTH=8, STABLE_CYCLES=4, INVERT=0).
// A windowed history model predicts every output; directed checks pin the documented scenarios.
module tb_dip_switch_debouncer;

  localparam int W = 8;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int n_cmp;
  int n_err;

  logic [W-1:0] exp_clean;
  logic [W-1:0] exp_rise;
  logic [W-1:0] exp_fall;
  logic         exp_chg;
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] s2_hist[$];

  dip_switch_debouncer #(
    .WIDTH(W),
    .STABLE_CYCLES(S),
    .INVERT(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_raw(sw_raw),
    .sw_clean(sw_clean),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_changed(sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a level is accepted once the last S synchronised samples all disagree with it.
  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0] s2v;
    logic [W-1:0] nxt;
    logic         all_diff;
    if (!rst_n) begin
      raw_hist.delete();
      s2_hist.delete();
      exp_clean = 8'h00;
      exp_rise  = 8'h00;
      exp_fall  = 8'h00;
      exp_chg   = 1'b0;
    end else begin
      raw_hist.push_back(sw_raw);
      if (raw_hist.size() > 3) void'(raw_hist.pop_front());
      s2v = (raw_hist.size() == 3) ? raw_hist[0] : 8'h00;
      s2_hist.push_back(s2v);
      if (s2_hist.size() > S) void'(s2_hist.pop_front());
      nxt = exp_clean;
      if (s2_hist.size() == S) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < S; j++) begin
            if (s2_hist[j][b] == exp_clean[b]) all_diff = 1'b0;
          end
          if (all_diff) nxt[b] = ~exp_clean[b];
        end
      end
      exp_rise  = nxt & ~exp_clean;
      exp_fall  = ~nxt & exp_clean;
      exp_chg   = |(nxt ^ exp_clean);
      exp_clean = nxt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check("clean", 32'(sw_clean), 32'(exp_clean));
    check("rise", 32'(sw_rise), 32'(exp_rise));
    check("fall", 32'(sw_fall), 32'(exp_fall));
    check("changed", 32'(sw_changed), 32'(exp_chg));
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_model();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clean"}, 32'(sw_clean), 32'h0);
    check({tag, "_rise"}, 32'(sw_rise), 32'h0);
    check({tag, "_fall"}, 32'(sw_fall), 32'h0);
    check({tag, "_chg"}, 32'(sw_changed), 32'h0);
  endtask

  initial begin
    logic [W-1:0] val;
    int hold;
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    sw_raw = 8'hFF;

    // 1: reset with all switches on, then full-latency rise on every bit
    @(negedge clk);
    @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    step(5);
    check("t1_early", 32'(sw_clean), 32'h00);
    step(1);
    check("t1_clean", 32'(sw_clean), 32'hFF);
    check("t1_rise", 32'(sw_rise), 32'hFF);
    check("t1_chg", 32'(sw_changed), 32'h1);
    step(1);
    check("t1_rise_once", 32'(sw_rise), 32'h00);
    check("t1_chg_once", 32'(sw_changed), 32'h0);

    // 2: bounce on bit 3 never qualifies, settling high does after full latency
    sw_raw = 8'h00;
    step(8);
    for (int i = 0; i < 10; i++) begin
      sw_raw[3] = ((i / 2) % 2 == 1) ? 1'b1 : 1'b0;
      step(1);
      check("t2_bounce", 32'(sw_clean[3]), 32'h0);
    end
    sw_raw[3] = 1'b1;
    step(5);
    check("t2_early", 32'(sw_clean[3]), 32'h0);
    step(1);
    check("t2_clean", 32'(sw_clean[3]), 32'h1);
    check("t2_rise", 32'(sw_rise), 32'h08);

    // 3: a 3-cycle pulse is rejected
    sw_raw[0] = 1'b1;
    step(3);
    sw_raw[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("t3_rise", 32'(sw_rise), 32'h00);
      check("t3_fall", 32'(sw_fall), 32'h00);
    end
    check("t3_clean", 32'(sw_clean), 32'h08);

    // 4: simultaneous rise and fall on different bits
    sw_raw = 8'h80;
    step(8);
    sw_raw = 8'h01;
    step(6);
    check("t4_rise", 32'(sw_rise), 32'h01);
    check("t4_fall", 32'(sw_fall), 32'h80);
    check("t4_chg", 32'(sw_changed), 32'h1);
    step(1);
    check("t4_clean", 32'(sw_clean), 32'h01);

    // 5: reset mid-count clears immediately and restarts qualification
    sw_raw = 8'h05;
    step(4);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t5_async");
    @(negedge clk);
    check_all_zero("t5_held");
    rst_n = 1'b1;
    step(5);
    check("t5_early", 32'(sw_clean), 32'h00);
    step(1);
    check("t5_clean", 32'(sw_clean), 32'h05);
    check("t5_rise", 32'(sw_rise), 32'h05);

    // 6: long-stable bit is untouched by a change on another bit
    sw_raw = 8'h02;
    step(1000);
    check("t6_hold", 32'(sw_clean), 32'h02);
    sw_raw = 8'h22;
    step(6);
    check("t6_rise", 32'(sw_rise), 32'h20);
    check("t6_clean", 32'(sw_clean), 32'h22);
    check("t6_fall", 32'(sw_fall), 32'h00);

    // random segments with occasional single-cycle glitches
    for (int seg = 0; seg < 60; seg++) begin
      val  = W'($urandom);
      hold = $urandom_range(1, 9);
      for (int c = 0; c < hold; c++) begin
        sw_raw = val;
        if ($urandom_range(0, 4) == 0) sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
        step(1);
      end
      if (seg == 30) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
